// File: rtl/mem_loader_pkg.sv
// Shared types and header field layout for the memory loader.
// Optional checksum trailer is enabled by defining MEM_LOADER_CHECKSUM_EN.
package mem_loader_pkg;

  localparam logic [31:0] MAGIC_DEFAULT = 32'hB007_10AD;

  localparam int unsigned TGT_BIT  = 31;
  localparam int unsigned LAST_BIT = 30;
  localparam int unsigned COUNT_W  = 16;

  localparam logic TGT_IMEM = 1'b0;
  localparam logic TGT_DMEM = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_LEN,
    PAYLOAD,
`ifdef MEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    ERROR,
    RUN
  } state_t;

  function automatic logic ready_in(state_t s);
    return (s == IDLE) || (s == HDR_ADDR) || (s == HDR_LEN) || (s == PAYLOAD)
`ifdef MEM_LOADER_CHECKSUM_EN
        || (s == CHECK)
`endif
        ;
  endfunction

  function automatic logic busy_in(state_t s);
    return (s == HDR_ADDR) || (s == HDR_LEN) || (s == PAYLOAD)
`ifdef MEM_LOADER_CHECKSUM_EN
        || (s == CHECK)
`endif
        ;
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams framed words into the instruction or data memory init port, then releases the CPU reset.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing 32-bit payload sum per frame.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter logic [31:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_din,
  output logic              imem_en,
  output logic [3:0]        imem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_din,
  output logic              dmem_en,
  output logic [3:0]        dmem_we,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  state_t              state, nxt;
  logic                tgt, last;
  logic [ADDR_W-1:0]   ptr;
  logic [COUNT_W-1:0]  left;
  logic                acc, frame_end;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0]         sum;
`endif

  always_comb begin
    acc       = s_valid && s_ready;
    nxt       = state;
    frame_end = 1'b0;
    case (state)
      IDLE:     if (acc) nxt = (s_data == MAGIC) ? HDR_ADDR : ERROR;
      HDR_ADDR: if (acc) nxt = HDR_LEN;
      HDR_LEN: begin
        if (acc) begin
          if (s_data[COUNT_W-1:0] != '0) begin
            nxt = PAYLOAD;
          end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
            nxt = CHECK;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end
      PAYLOAD: begin
        if (acc && left == COUNT_W'(1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          nxt = CHECK;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (acc) begin
          if (s_data == sum) frame_end = 1'b1;
          else               nxt = ERROR;
        end
      end
`endif
      default: ;
    endcase
    if (frame_end) nxt = last ? RUN : IDLE;
  end

  // Status outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      cpu_reset_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      tgt         <= TGT_IMEM;
      last        <= 1'b0;
      ptr         <= '0;
      left        <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
      imem_en     <= 1'b0;
      imem_we     <= '0;
      imem_addr   <= '0;
      imem_din    <= '0;
      dmem_en     <= 1'b0;
      dmem_we     <= '0;
      dmem_addr   <= '0;
      dmem_din    <= '0;
    end else begin
      state       <= nxt;
      s_ready     <= ready_in(nxt);
      busy_o      <= busy_in(nxt);
      error_o     <= (nxt == ERROR);
      cpu_reset_o <= (nxt != RUN);
      done_o      <= frame_end;
      imem_en     <= 1'b0;
      imem_we     <= '0;
      imem_addr   <= '0;
      imem_din    <= '0;
      dmem_en     <= 1'b0;
      dmem_we     <= '0;
      dmem_addr   <= '0;
      dmem_din    <= '0;
      if (acc) begin
        case (state)
          HDR_ADDR: begin
            tgt  <= s_data[TGT_BIT];
            last <= s_data[LAST_BIT];
            ptr  <= s_data[ADDR_W-1:0];
          end
          HDR_LEN: begin
            left <= s_data[COUNT_W-1:0];
`ifdef MEM_LOADER_CHECKSUM_EN
            sum  <= '0;
`endif
          end
          PAYLOAD: begin
            left <= left - 1'b1;
            ptr  <= ptr + 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum  <= sum + s_data;
`endif
            if (tgt == TGT_DMEM) begin
              dmem_en   <= 1'b1;
              dmem_we   <= '1;
              dmem_addr <= ptr;
              dmem_din  <= s_data;
            end else begin
              imem_en   <= 1'b1;
              imem_we   <= '1;
              imem_addr <= ptr;
              imem_din  <= s_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: frame-level write model plus directed literal checks.
module tb_mem_loader;

  localparam int unsigned AW    = 15;
  localparam logic [31:0] MAGIC = 32'hB007_10AD;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_din, dmem_din;
  logic          imem_en, dmem_en;
  logic [3:0]    imem_we, dmem_we;
  logic          cpu_reset_o, busy_o, done_o, error_o;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(AW), .MAGIC(MAGIC)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .imem_addr(imem_addr), .imem_din(imem_din), .imem_en(imem_en), .imem_we(imem_we),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_en(dmem_en), .dmem_we(dmem_we),
    .cpu_reset_o(cpu_reset_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_imem[$], exp_dmem[$];
  logic [AW-1:0] imem_log[$], dmem_log[$];
  logic [31:0]   payload[$];
  int            checks = 0, errors = 0;
  int            done_seen = 0, exp_done = 0;
  bit            exp_error = 1'b0, exp_last = 1'b0, run_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame-level model.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      run_seen = 1'b0;
      exp_imem.delete();
      exp_dmem.delete();
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
      check("rst_flags", 32'({busy_o, done_o, error_o}), 32'd0);
      check("rst_ports", 32'({imem_en, imem_we, dmem_en, dmem_we}) | 32'(imem_addr) | 32'(dmem_addr)
            | imem_din | dmem_din, 32'd0);
    end else begin
      if (imem_en) begin
        imem_log.push_back(imem_addr);
        if (exp_imem.size() == 0) begin
          checks++; errors++;
          $display("FAIL imem_unexpected: got write addr %h data %h, expected no write", imem_addr, imem_din);
        end else begin
          e = exp_imem.pop_front();
          check("imem_addr", 32'(imem_addr), 32'(e.addr));
          check("imem_din", imem_din, e.data);
          check("imem_we", 32'(imem_we), 32'hF);
        end
      end else begin
        check("imem_idle", 32'(imem_we) | 32'(imem_addr) | imem_din, 32'd0);
      end
      if (dmem_en) begin
        dmem_log.push_back(dmem_addr);
        if (exp_dmem.size() == 0) begin
          checks++; errors++;
          $display("FAIL dmem_unexpected: got write addr %h data %h, expected no write", dmem_addr, dmem_din);
        end else begin
          e = exp_dmem.pop_front();
          check("dmem_addr", 32'(dmem_addr), 32'(e.addr));
          check("dmem_din", dmem_din, e.data);
          check("dmem_we", 32'(dmem_we), 32'hF);
        end
      end else begin
        check("dmem_idle", 32'(dmem_we) | 32'(dmem_addr) | dmem_din, 32'd0);
      end
      if (done_o) begin
        done_seen++;
        if (exp_last) run_seen = 1'b1;
      end
      check("cpu_reset", 32'(cpu_reset_o), 32'(!run_seen));
      check("error_o", 32'(error_o), 32'(exp_error));
      if (exp_error || run_seen) check("s_ready_blocked", 32'(s_ready), 32'd0);
    end
  end

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int unsigned n;
    @(negedge clk);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        @(negedge clk);
      end
    end
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: s_ready %b after %0d cycles, expected 1", s_ready, n);
      s_valid = 1'b0;
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input int unsigned count, input int unsigned n_send,
                            input bit gaps, input logic [31:0] trailer_xor);
    logic [AW-1:0] base;
    logic [31:0]   sum;
    wr_t           e;
    base     = hdr[AW-1:0];
    exp_last = hdr[30];
    sum      = '0;
    send_word(MAGIC, gaps);
    send_word(hdr, gaps);
    send_word(count, gaps);
    for (int unsigned i = 0; i < n_send; i++) begin
      send_word(payload[i], gaps);
      e.addr = AW'((32'(base) + i) % (32'd1 << AW));
      e.data = payload[i];
      if (hdr[31]) exp_dmem.push_back(e);
      else         exp_imem.push_back(e);
      sum += payload[i];
    end
    if (n_send == count) begin
`ifdef MEM_LOADER_CHECKSUM_EN
      send_word(sum ^ trailer_xor, gaps);
      if (trailer_xor == 0) exp_done++;
      else                  exp_error = 1'b1;
`else
      if (trailer_xor == 0) exp_done++;
`endif
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    exp_error = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 check("s_ready_after_reset", 32'(s_ready), 32'd1);
  endtask

  initial begin
    int unsigned d0, i0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 check("s_ready_after_reset", 32'(s_ready), 32'd1);

    // Wrapping dmem frame, not last.
    payload = '{32'h11, 32'h22, 32'h33, 32'h44};
    d0 = dmem_log.size(); i0 = imem_log.size();
    send_frame(32'h8000_7FFE, 4, 4, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    check("wrap_count", dmem_log.size() - d0, 32'd4);
    check("wrap_a0", 32'(dmem_log[d0]),     32'h7FFE);
    check("wrap_a1", 32'(dmem_log[d0 + 1]), 32'h7FFF);
    check("wrap_a2", 32'(dmem_log[d0 + 2]), 32'h0000);
    check("wrap_a3", 32'(dmem_log[d0 + 3]), 32'h0001);
    check("wrap_no_imem", imem_log.size() - i0, 32'd0);
    check("wrap_cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("wrap_done", done_seen, 32'd1);
    check("wrap_idle_busy", 32'(busy_o), 32'd0);

    // Imem frame with random s_valid gaps.
    payload.delete();
    for (int unsigned i = 0; i < 6; i++) payload.push_back($urandom);
    send_frame(32'h0000_0100, 6, 6, 1'b1, 32'd0);
    repeat (3) @(negedge clk);
    check("gap_done", done_seen, exp_done);

    // Reset in the middle of a payload.
    payload.delete();
    for (int unsigned i = 0; i < 5; i++) payload.push_back($urandom);
    send_frame(32'h0000_0200, 5, 2, 1'b1, 32'd0);
    repeat (2) @(negedge clk);
    check("mid_busy", 32'(busy_o), 32'd1);
    check("mid_ready", 32'(s_ready), 32'd1);
    pulse_reset();

    // Single last frame into imem.
    payload = '{32'hAA, 32'hBB, 32'hCC};
    i0 = imem_log.size();
    send_frame(32'h4000_0010, 3, 3, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    check("last_count", imem_log.size() - i0, 32'd3);
    check("last_a0", 32'(imem_log[i0]),     32'h10);
    check("last_a1", 32'(imem_log[i0 + 1]), 32'h11);
    check("last_a2", 32'(imem_log[i0 + 2]), 32'h12);
    check("last_done", done_seen, 32'd3);
    check("last_cpu_reset", 32'(cpu_reset_o), 32'd0);
    check("last_ready", 32'(s_ready), 32'd0);

    // Bad magic.
    pulse_reset();
    d0 = dmem_log.size(); i0 = imem_log.size();
    send_word(32'hDEAD_BEEF, 1'b0);
    exp_error = 1'b1;
    repeat (5) @(negedge clk);
    check("bad_error", 32'(error_o), 32'd1);
    check("bad_ready", 32'(s_ready), 32'd0);
    check("bad_cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("bad_busy", 32'(busy_o), 32'd0);
    check("bad_no_writes", (imem_log.size() - i0) + (dmem_log.size() - d0), 32'd0);
    check("bad_done", done_seen, 32'd3);

    pulse_reset();
`ifdef MEM_LOADER_CHECKSUM_EN
    payload = '{32'd1, 32'd2, 32'd3};
    send_frame(32'h0000_0040, 3, 3, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    check("ck_good_done", done_seen, 32'd4);
    check("ck_good_error", 32'(error_o), 32'd0);
    send_frame(32'h0000_0040, 3, 3, 1'b0, 32'd1);
    repeat (3) @(negedge clk);
    check("ck_bad_error", 32'(error_o), 32'd1);
    check("ck_bad_done", done_seen, 32'd4);
    pulse_reset();
`endif
    payload.delete();
    d0 = dmem_log.size(); i0 = imem_log.size();
    send_frame(32'h8000_0000, 0, 0, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
`ifdef MEM_LOADER_CHECKSUM_EN
    check("zero_done", done_seen, 32'd5);
`else
    check("zero_done", done_seen, 32'd4);
`endif
    check("zero_no_writes", (imem_log.size() - i0) + (dmem_log.size() - d0), 32'd0);
    check("zero_error", 32'(error_o), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
